// File: rtl/datapath_module.sv
// Single-cycle 16-bit RISC datapath: PC, instruction/data memories, 8x16
// register file, ALU with carry register and a registered output port.
// All control comes from an external control unit; test mode freezes the
// core and lets a host preload both memories.
module datapath_module #(
    parameter int unsigned MEM_AW = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        flag_HLT,
    input  logic        test_normal,
    input  logic        ext_instr_we,
    input  logic [15:0] ext_instr_addr,
    input  logic [15:0] ext_instr_data,
    input  logic        ext_data_write_en,
    input  logic [15:0] ext_data_addr,
    input  logic [15:0] ext_data_data,
    output logic [15:0] mem_instr_out,
    input  logic        Src_Read_B,
    input  logic        Src_ALU_B,
    input  logic        ADC,
    input  logic        SUB,
    input  logic        SBB,
    input  logic        JMP,
    input  logic        flag_label_PC,
    input  logic        flag_Rm_PC,
    input  logic        flag_Rd_PC,
    input  logic        BRANCH,
    input  logic        data_write_en,
    input  logic        flag_mem_RF,
    input  logic        flag_ALU_RF,
    input  logic        flag_Rm_RF,
    input  logic        flag_PC_RF,
    input  logic        LHI,
    input  logic        LLI,
    input  logic        RF_write_en,
    input  logic        flag_OutR,
    output logic        Pre_C,
    output logic        Pre_V,
    output logic        Pre_Z,
    output logic        Pre_N,
    output logic [15:0] OutR
);

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 1 << MEM_AW;
    localparam int unsigned NREG  = 8;

    logic [DW-1:0] imem [DEPTH];
    logic [DW-1:0] dmem [DEPTH];
    logic [DW-1:0] rf   [NREG];
    logic [DW-1:0] pc;
    logic          c_reg;

    logic [MEM_AW-1:0] instr_addr;
    logic [2:0]        rd, rm, rn;
    logic [4:0]        imm5;
    logic [7:0]        imm8;
    logic [10:0]       imm11;
    logic [DW-1:0]     port_a, port_b, alu_b, b_eff, alu_res;
    logic [DW:0]       sum;
    logic              cin, sub_op, run;
    logic [MEM_AW-1:0] dmem_addr;
    logic [DW-1:0]     dmem_wdata, mem_rdata, rf_wdata, pc_inc, next_pc;
    logic              dmem_we;

    // Host address ports are wider than the memories; opcode bits are decoded outside.
    if (MEM_AW < 16) begin : g_unused
        logic unused_bits;
        assign unused_bits = ^{ext_instr_addr[15:MEM_AW], ext_data_addr[15:MEM_AW],
                               mem_instr_out[15:11]};
    end else begin : g_unused_op
        logic unused_bits;
        assign unused_bits = ^mem_instr_out[15:11];
    end

    assign run        = ~test_normal & flag_HLT;
    assign instr_addr = test_normal ? ext_instr_addr[MEM_AW-1:0] : pc[MEM_AW-1:0];
    assign mem_instr_out = imem[instr_addr];

    assign rd    = mem_instr_out[10:8];
    assign rm    = mem_instr_out[7:5];
    assign rn    = mem_instr_out[4:2];
    assign imm5  = mem_instr_out[4:0];
    assign imm8  = mem_instr_out[7:0];
    assign imm11 = mem_instr_out[10:0];

    assign port_a = rf[rm];
    assign port_b = rf[Src_Read_B ? rd : rn];
    assign alu_b  = Src_ALU_B ? {11'b0, imm5} : port_b;

    // ALU: 17-bit sum, subtraction as A + ~B + carry-in, SUB > SBB > ADC > ADD
    always_comb begin
        sub_op = SUB | SBB;
        cin    = 1'b0;
        if (SUB)            cin = 1'b1;
        else if (SBB | ADC) cin = c_reg;
        b_eff   = sub_op ? ~alu_b : alu_b;
        sum     = {1'b0, port_a} + {1'b0, b_eff} + 17'(cin);
        alu_res = sum[DW-1:0];
        Pre_C   = sum[DW];
        Pre_V   = (port_a[DW-1] == b_eff[DW-1]) & (alu_res[DW-1] != port_a[DW-1]);
        Pre_Z   = (alu_res == '0);
        Pre_N   = alu_res[DW-1];
    end

    // Data memory port is owned by the host in test mode, by the core otherwise
    always_comb begin
        dmem_addr  = alu_res[MEM_AW-1:0];
        dmem_wdata = port_b;
        dmem_we    = data_write_en;
        if (test_normal) begin
            dmem_addr  = ext_data_addr[MEM_AW-1:0];
            dmem_wdata = ext_data_data;
            dmem_we    = ext_data_write_en;
        end
    end

    assign mem_rdata = dmem[dmem_addr];
    assign pc_inc    = pc + 16'd1;

    // Register-file write-data select, ALU result when nothing is selected
    always_comb begin
        rf_wdata = alu_res;
        if (flag_mem_RF)      rf_wdata = mem_rdata;
        else if (flag_ALU_RF) rf_wdata = alu_res;
        else if (flag_Rm_RF)  rf_wdata = port_a;
        else if (flag_PC_RF)  rf_wdata = pc_inc;
        else if (LHI)         rf_wdata = {imm8, port_b[7:0]};
        else if (LLI)         rf_wdata = {8'h00, imm8};
    end

    // Next-PC select: register jumps, then labelled jump, then branch
    always_comb begin
        next_pc = pc_inc;
        if (flag_Rm_PC)                next_pc = port_a;
        else if (flag_Rd_PC)           next_pc = rf[rd];
        else if (JMP & flag_label_PC)  next_pc = pc_inc + {{5{imm11[10]}}, imm11};
        else if (BRANCH)               next_pc = pc_inc + {{8{imm8[7]}}, imm8};
    end

    // Instruction memory: host writes only
    always_ff @(posedge clk) begin
        if (test_normal & ext_instr_we) imem[ext_instr_addr[MEM_AW-1:0]] <= ext_instr_data;
    end

    // Data memory write
    always_ff @(posedge clk) begin
        if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
    end

    // Core state: PC, register file, output register, carry
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc    <= '0;
            OutR  <= '0;
            c_reg <= 1'b0;
            for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
        end else if (run) begin
            pc <= next_pc;
            if (RF_write_en) rf[rd] <= rf_wdata;
            if (flag_OutR)   OutR   <= port_a;
            if (flag_ALU_RF) c_reg  <= Pre_C;
        end
    end

endmodule

// File: tb/tb_datapath_module.sv
// Scoreboard bench for datapath_module: the stimulus process acts as the
// control unit, runs an instruction-level reference model and queues the
// expected outputs; a negedge monitor pops and compares them.
module tb_datapath_module;

    logic        clk;
    logic        clr, flag_HLT, test_normal;
    logic        ext_instr_we, ext_data_write_en;
    logic [15:0] ext_instr_addr, ext_instr_data, ext_data_addr, ext_data_data;
    logic [15:0] mem_instr_out, OutR;
    logic        Src_Read_B, Src_ALU_B, ADC, SUB, SBB, JMP, flag_label_PC;
    logic        flag_Rm_PC, flag_Rd_PC, BRANCH, data_write_en;
    logic        flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF, LHI, LLI;
    logic        RF_write_en, flag_OutR;
    logic        Pre_C, Pre_V, Pre_Z, Pre_N;

    datapath_module #(.MEM_AW(8)) dut (
        .clk(clk), .clr(clr), .flag_HLT(flag_HLT), .test_normal(test_normal),
        .ext_instr_we(ext_instr_we), .ext_instr_addr(ext_instr_addr),
        .ext_instr_data(ext_instr_data), .ext_data_write_en(ext_data_write_en),
        .ext_data_addr(ext_data_addr), .ext_data_data(ext_data_data),
        .mem_instr_out(mem_instr_out), .Src_Read_B(Src_Read_B), .Src_ALU_B(Src_ALU_B),
        .ADC(ADC), .SUB(SUB), .SBB(SBB), .JMP(JMP), .flag_label_PC(flag_label_PC),
        .flag_Rm_PC(flag_Rm_PC), .flag_Rd_PC(flag_Rd_PC), .BRANCH(BRANCH),
        .data_write_en(data_write_en), .flag_mem_RF(flag_mem_RF),
        .flag_ALU_RF(flag_ALU_RF), .flag_Rm_RF(flag_Rm_RF), .flag_PC_RF(flag_PC_RF),
        .LHI(LHI), .LLI(LLI), .RF_write_en(RF_write_en), .flag_OutR(flag_OutR),
        .Pre_C(Pre_C), .Pre_V(Pre_V), .Pre_Z(Pre_Z), .Pre_N(Pre_N), .OutR(OutR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic hlt, srb, sab, adc, sub, sbb, jmp, lbl, rmpc, rdpc, br, dwe;
        logic memrf, alurf, rmrf, pcrf, lhi, lli, rfwe, outr;
    } ctl_t;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] exp;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    // Reference machine state
    logic [15:0] m_imem [256];
    logic [15:0] m_dmem [256];
    logic [15:0] m_rf   [8];
    logic [15:0] m_pc, m_outr;
    logic        m_c;

    function automatic string kname(input int k);
        case (k)
            0: return "OutR";
            1: return "mem_instr_out";
            2: return "Pre_C";
            3: return "Pre_V";
            4: return "Pre_Z";
            5: return "Pre_N";
            default: return "unknown";
        endcase
    endfunction

    function automatic int sx(input int v, input int bits);
        return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    endfunction

    task automatic push(input int kind, input logic [15:0] v);
        exp_t e;
        e.cyc = cyc; e.kind = kind; e.exp = v;
        q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input ctl_t c);
        flag_HLT = c.hlt; Src_Read_B = c.srb; Src_ALU_B = c.sab;
        ADC = c.adc; SUB = c.sub; SBB = c.sbb; JMP = c.jmp; flag_label_PC = c.lbl;
        flag_Rm_PC = c.rmpc; flag_Rd_PC = c.rdpc; BRANCH = c.br; data_write_en = c.dwe;
        flag_mem_RF = c.memrf; flag_ALU_RF = c.alurf; flag_Rm_RF = c.rmrf;
        flag_PC_RF = c.pcrf; LHI = c.lhi; LLI = c.lli; RF_write_en = c.rfwe;
        flag_OutR = c.outr;
    endtask

    // One instruction of the machine, from the architectural rules
    task automatic step(input ctl_t c);
        logic [15:0] ins, pbv;
        int rd, rm, rn, imm5, imm8, imm11, a, b, cin, us, res, sr, wd, npc, mrd;
        bit is_sub, carry, ovf;
        ins   = m_imem[m_pc[7:0]];
        rd    = int'(ins[10:8]);
        rm    = int'(ins[7:5]);
        rn    = int'(ins[4:2]);
        imm5  = int'(ins[4:0]);
        imm8  = int'(ins[7:0]);
        imm11 = int'(ins[10:0]);
        a     = int'(m_rf[rm]);
        pbv   = m_rf[c.srb ? rd : rn];
        b     = c.sab ? imm5 : int'(pbv);
        is_sub = c.sub || c.sbb;
        if (c.sub)                 cin = 1;
        else if (c.sbb || c.adc)   cin = int'(m_c);
        else                       cin = 0;
        us    = is_sub ? a + (65535 - b) + cin : a + b + cin;
        res   = us % 65536;
        carry = (us > 65535);
        sr    = is_sub ? sx(a, 16) - sx(b, 16) - 1 + cin : sx(a, 16) + sx(b, 16) + cin;
        ovf   = (sr > 32767) || (sr < -32768);
        push(0, m_outr);
        push(1, ins);
        push(2, 16'(carry));
        push(3, 16'(ovf));
        push(4, 16'(res == 0));
        push(5, 16'(res >= 32768));
        mrd = int'(m_dmem[res % 256]);
        if (c.dwe) m_dmem[res % 256] = pbv;
        if (c.hlt) begin
            if (c.memrf)      wd = mrd;
            else if (c.alurf) wd = res;
            else if (c.rmrf)  wd = a;
            else if (c.pcrf)  wd = int'(m_pc) + 1;
            else if (c.lhi)   wd = (imm8 << 8) | (int'(pbv) % 256);
            else if (c.lli)   wd = imm8;
            else              wd = res;
            if (c.rmpc)               npc = a;
            else if (c.rdpc)          npc = int'(m_rf[rd]);
            else if (c.jmp && c.lbl)  npc = int'(m_pc) + 1 + sx(imm11, 11);
            else if (c.br)            npc = int'(m_pc) + 1 + sx(imm8, 8);
            else                      npc = int'(m_pc) + 1;
            m_pc = 16'(npc);
            if (c.rfwe)  m_rf[rd] = 16'(wd);
            if (c.outr)  m_outr = 16'(a);
            if (c.alurf) m_c = carry;
        end
    endtask

    task automatic run(input ctl_t c);
        next_cycle();
        drive(c);
        step(c);
    endtask

    // Mid-cycle asynchronous reset with the core halted for the rest of the cycle
    task automatic pulse_reset();
        next_cycle();
        drive('0);
        test_normal = 1'b0;
        clr = 1'b1;
        #2;
        clr = 1'b0;
        m_pc = '0; m_outr = '0; m_c = 1'b0;
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        push(0, 16'h0000);
        push(1, m_imem[0]);
    endtask

    function automatic ctl_t rand_ctl();
        ctl_t c;
        c = '0;
        c.hlt   = ($urandom % 8) != 0;
        c.srb   = $urandom % 2;
        c.sab   = $urandom % 2;
        c.adc   = ($urandom % 3) == 0;
        c.sub   = ($urandom % 4) == 0;
        c.sbb   = ($urandom % 4) == 0;
        c.jmp   = ($urandom % 4) == 0;
        c.lbl   = $urandom % 2;
        c.rmpc  = ($urandom % 16) == 0;
        c.rdpc  = ($urandom % 16) == 0;
        c.br    = ($urandom % 8) == 0;
        c.dwe   = ($urandom % 4) == 0;
        c.memrf = ($urandom % 4) == 0;
        c.alurf = ($urandom % 3) == 0;
        c.rmrf  = ($urandom % 4) == 0;
        c.pcrf  = ($urandom % 4) == 0;
        c.lhi   = ($urandom % 4) == 0;
        c.lli   = ($urandom % 4) == 0;
        c.rfwe  = $urandom % 2;
        c.outr  = ($urandom % 3) == 0;
        return c;
    endfunction

    // Monitor: compare every expectation due this cycle
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            case (e.kind)
                0:       act = OutR;
                1:       act = mem_instr_out;
                2:       act = 16'(Pre_C);
                3:       act = 16'(Pre_V);
                4:       act = 16'(Pre_Z);
                default: act = 16'(Pre_N);
            endcase
            checks++;
            if (e.cyc != cyc || act !== e.exp) begin
                failures++;
                $display("FAIL %s cyc=%0d got=%h expected=%h", kname(e.kind), e.cyc, act, e.exp);
            end
        end
    end

    initial begin
        ctl_t c_ldr, c_alu, c_out, c_str, c_lhi, c_sub, c_load;
        logic [15:0] ra;

        drive('0);
        clr = 1'b1; test_normal = 1'b1;
        ext_instr_we = 1'b0; ext_data_write_en = 1'b0;
        ext_instr_addr = '0; ext_instr_data = '0; ext_data_addr = '0; ext_data_data = '0;
        m_pc = '0; m_outr = '0; m_c = 1'b0;
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        for (int i = 0; i < 256; i++) begin
            m_imem[i] = 16'($urandom);
            m_dmem[i] = 16'($urandom);
        end
        m_imem[0] = 16'h0100;  // LDR R1,[R0+0]
        m_imem[1] = 16'h0201;  // LDR R2,[R0+1]
        m_imem[2] = 16'h0328;  // ADD R3,R1,R2
        m_imem[3] = 16'h0060;  // OUT R3
        m_imem[4] = 16'h0101;  // STR R1,[R0+1]
        m_imem[5] = 16'h0201;  // LDR R2,[R0+1]
        m_imem[6] = 16'h0040;  // OUT R2
        m_imem[7] = 16'h0156;  // LHI R1,#56
        m_imem[8] = 16'h0020;  // OUT R1
        m_imem[9] = 16'h0324;  // SUB R3,R1,R1
        m_dmem[0] = 16'h1234;
        m_dmem[1] = 16'h4321;

        next_cycle();
        clr = 1'b0;
        push(0, 16'h0000);

        // Host preload with the core enabled-but-frozen by test mode
        c_load = '0;
        c_load.hlt = 1'b1; c_load.rfwe = 1'b1; c_load.outr = 1'b1;
        c_load.br = 1'b1; c_load.dwe = 1'b1; c_load.alurf = 1'b1;
        for (int i = 0; i < 256; i++) begin
            next_cycle();
            drive(c_load);
            ext_instr_we      = 1'b1;
            ext_instr_addr    = {8'($urandom), 8'(i)};
            ext_instr_data    = m_imem[i];
            ext_data_write_en = 1'b1;
            ext_data_addr     = {8'($urandom), 8'(i)};
            ext_data_data     = m_dmem[i];
            if (i % 64 == 0) push(0, 16'h0000);
        end
        next_cycle();
        ext_instr_we = 1'b0; ext_data_write_en = 1'b0;
        push(0, 16'h0000);
        for (int k = 0; k < 16; k++) begin
            next_cycle();
            ra = (k < 6) ? 16'(k) : 16'($urandom);
            ext_instr_addr = ra;
            push(1, m_imem[ra[7:0]]);
        end

        // Leave test mode without reset: PC must still be 0
        next_cycle();
        drive('0);
        test_normal = 1'b0;
        push(1, m_imem[0]);
        push(0, 16'h0000);

        pulse_reset();

        c_ldr = '0; c_ldr.hlt = 1; c_ldr.sab = 1; c_ldr.memrf = 1; c_ldr.rfwe = 1;
        c_alu = '0; c_alu.hlt = 1; c_alu.alurf = 1; c_alu.rfwe = 1;
        c_out = '0; c_out.hlt = 1; c_out.outr = 1;
        c_str = '0; c_str.hlt = 1; c_str.srb = 1; c_str.sab = 1; c_str.dwe = 1;
        c_lhi = '0; c_lhi.hlt = 1; c_lhi.srb = 1; c_lhi.lhi = 1; c_lhi.rfwe = 1;
        c_sub = c_alu; c_sub.sub = 1;

        run(c_ldr);
        run(c_ldr);
        run(c_alu); push(4, 16'h0); push(2, 16'h0);
        run(c_out);
        run(c_str); push(0, 16'h5555);
        run(c_ldr);
        run(c_out);
        run(c_lhi); push(0, 16'h1234);
        run(c_out);
        run(c_sub); push(0, 16'h5634); push(4, 16'h1); push(2, 16'h1);
        for (int i = 0; i < 3; i++) begin
            run('0);
            push(1, m_imem[10]);
        end

        // Randomised control sequence with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom % 400 == 0) pulse_reset();
            else run(rand_ctl());
        end

        next_cycle();
        next_cycle();
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
